// File: rtl/cdcm_tx_pkg.sv
// Shared types and constants for the CDCM TX/RX link controllers.
package cdcm_tx_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_SCAN,
        ST_CHECK,
        ST_TRAIN,
        ST_RUN,
        ST_ERROR
    } state_e;

    localparam int unsigned kTableEntries     = 8;
    localparam logic [7:0]  kDefTrainPattern  = 8'hF0;
    localparam logic [7:0]  kDefIdlePattern   = 8'hF0;

endpackage

// File: rtl/cdcm_offset_checker.sv
// Combinational check that every offset-table entry is the previous entry plus
// one, modulo 2^kWidth (so FF -> 00 is a legal step).
module cdcm_offset_checker
    import cdcm_tx_pkg::*;
#(
    parameter int unsigned kWidth = 8
) (
    input  logic [kTableEntries*kWidth-1:0] table_i,
    output logic                            pass_o
);

    always_comb begin
        pass_o = 1'b1;
        for (int unsigned i = 1; i < kTableEntries; i++) begin
            if (table_i[i*kWidth +: kWidth] != kWidth'(table_i[(i-1)*kWidth +: kWidth] + kWidth'(1)))
                pass_o = 1'b0;
        end
    end

endmodule

// File: rtl/cdcm_tx_link_ctrl.sv
// Sequences one CDCM TX lane: ioReset, scan wait, table check, training, user RUN.
// Optional statistics counters are enabled with `define CDCM_TX_LINK_STAT_EN.
module cdcm_tx_link_ctrl
    import cdcm_tx_pkg::*;
#(
    parameter int unsigned      kDevW         = 8,
    parameter int unsigned      kWidthScanTdc = 8,
    parameter int unsigned      kResetCycles  = 16,
    parameter int unsigned      kScanTimeout  = 1024,
    parameter int unsigned      kTrainCycles  = 256,
    parameter logic [kDevW-1:0] kTrainPattern = kDefTrainPattern,
    parameter logic [kDevW-1:0] kIdlePattern  = kDefIdlePattern
) (
    input  logic                                   clkDivIn,
    input  logic                                   rstN,
    input  logic                                   initReq,
    input  logic [kDevW-1:0]                       txDataIn,
    input  logic                                   txValid,
    output logic                                   txReady,
    output logic [kDevW-1:0]                       dOutToDevice,
    output logic                                   ioResetOut,
    input  logic                                   scanFinishedIn,
    input  logic [kTableEntries*kWidthScanTdc-1:0] offsetTableIn,
    output logic [kTableEntries*kWidthScanTdc-1:0] offsetLatched,
`ifdef CDCM_TX_LINK_STAT_EN
    output logic [31:0]                            txWordCount,
    output logic [31:0]                            idleCount,
`endif
    output logic                                   linkUp,
    output logic                                   tableError,
    output logic                                   scanTimeout
);

    localparam int unsigned kCntMax0 = (kResetCycles > kScanTimeout) ? kResetCycles : kScanTimeout;
    localparam int unsigned kCntMax  = (kCntMax0 > kTrainCycles) ? kCntMax0 : kTrainCycles;
    localparam int unsigned kCntW    = $clog2(kCntMax + 1);

    state_e                                 state_q, state_d;
    logic [kCntW-1:0]                       cnt_q, cnt_d;
    logic [kDevW-1:0]                       dout_q, dout_d;
    logic                                   io_q, io_d;
    logic                                   ready_q, ready_d;
    logic                                   link_q, link_d;
    logic                                   tblerr_q, tblerr_d;
    logic                                   scanto_q, scanto_d;
    logic [kTableEntries*kWidthScanTdc-1:0] offset_q, offset_d;
    logic                                   table_ok;
    logic                                   accept;

    cdcm_offset_checker #(
        .kWidth (kWidthScanTdc)
    ) u_checker (
        .table_i (offsetTableIn),
        .pass_o  (table_ok)
    );

    assign accept = txValid & ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tblerr_d = tblerr_q;
        scanto_d = scanto_q;
        offset_d = offset_q;
        unique case (state_q)
            ST_RESET: begin
                if (cnt_q == kCntW'(kResetCycles - 1)) begin
                    state_d = ST_WAIT_SCAN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + kCntW'(1);
                end
            end
            ST_WAIT_SCAN: begin
                if (scanFinishedIn) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else if (cnt_q == kCntW'(kScanTimeout - 1)) begin
                    state_d  = ST_ERROR;
                    scanto_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + kCntW'(1);
                end
            end
            ST_CHECK: begin
                offset_d = offsetTableIn;
                cnt_d    = '0;
                if (table_ok) begin
                    state_d = ST_TRAIN;
                end else begin
                    state_d  = ST_ERROR;
                    tblerr_d = 1'b1;
                end
            end
            ST_TRAIN: begin
                if (cnt_q == kCntW'(kTrainCycles - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + kCntW'(1);
                end
            end
            ST_RUN: begin
                if (!scanFinishedIn) begin
                    state_d  = ST_ERROR;
                    scanto_d = 1'b1;
                end
            end
            ST_ERROR: ;
            default: state_d = ST_RESET;
        endcase
        if (initReq) begin
            state_d  = ST_RESET;
            cnt_d    = '0;
            tblerr_d = 1'b0;
            scanto_d = 1'b0;
        end
        // A word accepted on the final RUN cycle is still emitted, even when leaving RUN.
        if (accept)
            dout_d = txDataIn;
        else if (state_q == ST_TRAIN)
            dout_d = kTrainPattern;
        else
            dout_d = kIdlePattern;
        io_d    = (state_d == ST_RESET);
        ready_d = (state_d == ST_RUN);
        link_d  = (state_d == ST_RUN);
    end

    always_ff @(posedge clkDivIn or negedge rstN) begin
        if (!rstN) begin
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            dout_q   <= kIdlePattern;
            io_q     <= 1'b1;
            ready_q  <= 1'b0;
            link_q   <= 1'b0;
            tblerr_q <= 1'b0;
            scanto_q <= 1'b0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            io_q     <= io_d;
            ready_q  <= ready_d;
            link_q   <= link_d;
            tblerr_q <= tblerr_d;
            scanto_q <= scanto_d;
            offset_q <= offset_d;
        end
    end

`ifdef CDCM_TX_LINK_STAT_EN
    logic [31:0] words_q, idles_q;

    always_ff @(posedge clkDivIn or negedge rstN) begin
        if (!rstN) begin
            words_q <= '0;
            idles_q <= '0;
        end else if (state_d == ST_RESET) begin
            words_q <= '0;
            idles_q <= '0;
        end else begin
            if (accept && words_q != '1)
                words_q <= words_q + 32'd1;
            if (state_q == ST_RUN && !accept && idles_q != '1)
                idles_q <= idles_q + 32'd1;
        end
    end

    assign txWordCount = words_q;
    assign idleCount   = idles_q;
`endif

    assign txReady       = ready_q;
    assign dOutToDevice  = dout_q;
    assign ioResetOut    = io_q;
    assign offsetLatched = offset_q;
    assign linkUp        = link_q;
    assign tableError    = tblerr_q;
    assign scanTimeout   = scanto_q;

endmodule

// File: tb/tb_cdcm_tx_link_ctrl.sv
// Directed self-checking bench for cdcm_tx_link_ctrl (stat checks under CDCM_TX_LINK_STAT_EN).
module tb_cdcm_tx_link_ctrl;

    logic        clkDivIn = 1'b0;
    logic        rstN, initReq, txValid, scanFinishedIn;
    logic [7:0]  txDataIn;
    logic [63:0] offsetTableIn;
    logic        txReady, ioResetOut, linkUp, tableError, scanTimeout;
    logic [7:0]  dOutToDevice;
    logic [63:0] offsetLatched;
`ifdef CDCM_TX_LINK_STAT_EN
    logic [31:0] txWordCount, idleCount;
`endif

    localparam logic [63:0] kGoodTable = 64'h020100FFFEFDFCFB;
    localparam logic [63:0] kBadTable  = 64'h020105FFFEFDFCFB;

    int checks   = 0;
    int failures = 0;

    cdcm_tx_link_ctrl dut (
        .clkDivIn       (clkDivIn),
        .rstN           (rstN),
        .initReq        (initReq),
        .txDataIn       (txDataIn),
        .txValid        (txValid),
        .txReady        (txReady),
        .dOutToDevice   (dOutToDevice),
        .ioResetOut     (ioResetOut),
        .scanFinishedIn (scanFinishedIn),
        .offsetTableIn  (offsetTableIn),
        .offsetLatched  (offsetLatched),
`ifdef CDCM_TX_LINK_STAT_EN
        .txWordCount    (txWordCount),
        .idleCount      (idleCount),
`endif
        .linkUp         (linkUp),
        .tableError     (tableError),
        .scanTimeout    (scanTimeout)
    );

    always #5 clkDivIn = ~clkDivIn;

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clkDivIn);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; initReq = 1'b0; txValid = 1'b0; txDataIn = '0;
        scanFinishedIn = 1'b0; offsetTableIn = kGoodTable;
        repeat (5) tick();
        checks++; if (ioResetOut !== 1'b1) begin failures++; $display("FAIL rst_io got=%b exp=1", ioResetOut); end
        checks++; if (dOutToDevice !== 8'hF0) begin failures++; $display("FAIL rst_dout got=%h exp=f0", dOutToDevice); end
        checks++; if ({txReady, linkUp, tableError, scanTimeout} !== 4'b0000) begin
            failures++; $display("FAIL rst_flags got=%b exp=0000", {txReady, linkUp, tableError, scanTimeout}); end
        checks++; if (offsetLatched !== 64'h0) begin failures++; $display("FAIL rst_offset got=%h exp=0", offsetLatched); end
    endtask

    task automatic test_power_up();
        int fall_at = 0;
        int n = 0;
        int train_bad = 0;
        rstN = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!ioResetOut && fall_at == 0) fall_at = i;
        end
        checks++; if (fall_at !== 16) begin failures++; $display("FAIL pu_reset_len got=%0d exp=16", fall_at); end
        scanFinishedIn = 1'b1;
        do begin
            tick();
            n++;
            if (n == 1) begin
                checks++; if (offsetLatched !== 64'h0) begin failures++; $display("FAIL pu_check_pre got=%h exp=0", offsetLatched); end
            end
            if (n == 2) begin
                checks++; if (offsetLatched !== kGoodTable) begin failures++; $display("FAIL pu_latch got=%h exp=%h", offsetLatched, kGoodTable); end
            end
            if (n >= 3 && !linkUp && (dOutToDevice !== 8'hF0 || txReady !== 1'b0)) train_bad++;
        end while (!linkUp && n < 400);
        checks++; if (n !== 258) begin failures++; $display("FAIL pu_link_delay got=%0d exp=258", n); end
        checks++; if (train_bad !== 0) begin failures++; $display("FAIL pu_train_words got=%0d exp=0", train_bad); end
        checks++; if ({txReady, tableError} !== 2'b10) begin failures++; $display("FAIL pu_run_flags got=%b exp=10", {txReady, tableError}); end
    endtask

    task automatic test_run_handshake();
        logic [7:0] data [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            txValid = 1'b1; txDataIn = data[i];
            tick();
            checks++; if (dOutToDevice !== data[i] || txReady !== 1'b1) begin
                failures++; $display("FAIL hs_word%0d got=%h/%b exp=%h/1", i, dOutToDevice, txReady, data[i]); end
        end
        txValid = 1'b0;
        tick();
        checks++; if (dOutToDevice !== 8'hF0) begin failures++; $display("FAIL hs_idle got=%h exp=f0", dOutToDevice); end
`ifdef CDCM_TX_LINK_STAT_EN
        checks++; if (txWordCount !== 32'd3 || idleCount !== 32'd1) begin
            failures++; $display("FAIL hs_stats got=%0d/%0d exp=3/1", txWordCount, idleCount); end
`endif
    endtask

    task automatic test_back_to_back();
        txValid = 1'b1; txDataIn = 8'h44; initReq = 1'b1;
        tick();
        txValid = 1'b0; initReq = 1'b0;
        checks++; if (dOutToDevice !== 8'h44) begin failures++; $display("FAIL b2b_inflight got=%h exp=44", dOutToDevice); end
        checks++; if ({ioResetOut, linkUp, txReady} !== 3'b100) begin
            failures++; $display("FAIL b2b_flags got=%b exp=100", {ioResetOut, linkUp, txReady}); end
`ifdef CDCM_TX_LINK_STAT_EN
        checks++; if (txWordCount !== 32'd0 || idleCount !== 32'd0) begin
            failures++; $display("FAIL b2b_stats got=%0d/%0d exp=0/0", txWordCount, idleCount); end
`endif
    endtask

    task automatic test_init_mid_train();
        int n = 0;
        do begin tick(); n++; end while (ioResetOut && n < 100);
        checks++; if (n !== 16) begin failures++; $display("FAIL mt_reset1 got=%0d exp=16", n); end
        repeat (2 + 100) tick();
        checks++; if (linkUp !== 1'b0 || dOutToDevice !== 8'hF0) begin
            failures++; $display("FAIL mt_training got=%b/%h exp=0/f0", linkUp, dOutToDevice); end
        initReq = 1'b1;
        tick();
        initReq = 1'b0;
        checks++; if (ioResetOut !== 1'b1) begin failures++; $display("FAIL mt_io_rise got=%b exp=1", ioResetOut); end
`ifdef CDCM_TX_LINK_STAT_EN
        checks++; if (txWordCount !== 32'd0 || idleCount !== 32'd0) begin
            failures++; $display("FAIL mt_stats got=%0d/%0d exp=0/0", txWordCount, idleCount); end
`endif
        n = 0;
        do begin tick(); n++; end while (ioResetOut && n < 100);
        checks++; if (n !== 16) begin failures++; $display("FAIL mt_reset2 got=%0d exp=16", n); end
        n = 0;
        do begin tick(); n++; end while (!linkUp && n < 400);
        checks++; if (n !== 258) begin failures++; $display("FAIL mt_retrain got=%0d exp=258", n); end
    endtask

    task automatic test_scan_loss();
        scanFinishedIn = 1'b0;
        tick();
        scanFinishedIn = 1'b1;
        checks++; if ({linkUp, txReady, scanTimeout, ioResetOut} !== 4'b0010) begin
            failures++; $display("FAIL sl_flags got=%b exp=0010", {linkUp, txReady, scanTimeout, ioResetOut}); end
        repeat (3) tick();
        checks++; if (linkUp !== 1'b0 || scanTimeout !== 1'b1 || dOutToDevice !== 8'hF0) begin
            failures++; $display("FAIL sl_hold got=%b/%b/%h exp=0/1/f0", linkUp, scanTimeout, dOutToDevice); end
        initReq = 1'b1;
        tick();
        initReq = 1'b0;
        checks++; if (scanTimeout !== 1'b0 || ioResetOut !== 1'b1) begin
            failures++; $display("FAIL sl_clear got=%b/%b exp=0/1", scanTimeout, ioResetOut); end
        checks++; if (offsetLatched !== kGoodTable) begin failures++; $display("FAIL sl_retain got=%h exp=%h", offsetLatched, kGoodTable); end
    endtask

    task automatic test_bad_table();
        int n = 0;
        offsetTableIn = kBadTable;
        do begin tick(); n++; end while (!tableError && n < 100);
        checks++; if (n !== 18) begin failures++; $display("FAIL bt_delay got=%0d exp=18", n); end
        checks++; if ({linkUp, ioResetOut, txReady} !== 3'b000 || dOutToDevice !== 8'hF0) begin
            failures++; $display("FAIL bt_state got=%b/%h exp=000/f0", {linkUp, ioResetOut, txReady}, dOutToDevice); end
        checks++; if (offsetLatched !== kBadTable) begin failures++; $display("FAIL bt_latch got=%h exp=%h", offsetLatched, kBadTable); end
        initReq = 1'b1;
        tick();
        initReq = 1'b0;
        checks++; if (tableError !== 1'b0 || ioResetOut !== 1'b1) begin
            failures++; $display("FAIL bt_clear got=%b/%b exp=0/1", tableError, ioResetOut); end
    endtask

    task automatic test_scan_timeout();
        int n = 0;
        offsetTableIn = kGoodTable;
        scanFinishedIn = 1'b0;
        do begin tick(); n++; end while (ioResetOut && n < 100);
        checks++; if (n !== 16) begin failures++; $display("FAIL to_reset got=%0d exp=16", n); end
        n = 0;
        do begin tick(); n++; end while (!scanTimeout && n < 2000);
        checks++; if (n !== 1024) begin failures++; $display("FAIL to_cycles got=%0d exp=1024", n); end
        repeat (3) tick();
        checks++; if ({scanTimeout, ioResetOut, linkUp, txReady, tableError} !== 5'b10000) begin
            failures++; $display("FAIL to_error got=%b exp=10000", {scanTimeout, ioResetOut, linkUp, txReady, tableError}); end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_run_handshake();
        test_back_to_back();
        test_init_mid_train();
        test_scan_loss();
        test_bad_table();
        test_scan_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
